// File: rtl/jalr_pkg.sv
// Shared types and helpers for the jump-target / return-address-stack unit.
package jalr_pkg;

    // Stack operation decoded from an IF-stage instruction
    typedef enum logic [1:0] {
        RAS_NONE,
        RAS_PUSH,
        RAS_POP,
        RAS_POPPUSH
    } ras_op_e;

    // Registers that the calling convention treats as link registers
    localparam logic [4:0] LINK_X1 = 5'd1;
    localparam logic [4:0] LINK_X5 = 5'd5;

    function automatic logic is_link(input logic [4:0] r);
        return (r == LINK_X1) || (r == LINK_X5);
    endfunction

endpackage

// File: rtl/jalr_target_calc.sv
// Resolved JAL/JALR target: picks the base (PC or rs1), adds the immediate,
// and clears bit 0 for JALR. Purely combinational.
module jalr_target_calc
    import jalr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_jalr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] target
);

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;

    // Two's-complement add: a negative immediate works without sign handling,
    // and the carry out is simply dropped.
    assign base   = is_jalr ? rs1_data : pc;
    assign sum    = base + imm;
    assign target = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;

endmodule

// File: rtl/jalr_ras.sv
// Jump-target unit with a circular return-address stack.
// IF side: same-cycle return prediction plus stack update on the next edge.
// EX side: combinational resolved target and JALR mispredict flag.
// Build option: define JALR_RAS_EN to include the stack; without it the unit
// never predicts, so every valid JALR reports a mispredict.
module jalr_ras
    import jalr_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic            if_stall,
    input  logic            if_is_jal,
    input  logic            if_is_jalr,
    input  logic [4:0]      if_rd,
    input  logic [4:0]      if_rs1,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_valid,
    output logic [XLEN-1:0] pred_target,
    output logic [PW-1:0]   ckpt_tos,
    output logic [PW:0]     ckpt_cnt,
    input  logic            restore,
    input  logic [PW-1:0]   restore_tos,
    input  logic [PW:0]     restore_cnt,
    input  logic            ex_valid,
    input  logic            ex_is_jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_rs1_data,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            ex_pred_valid,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic [XLEN-1:0] ex_target,
    output logic            ex_mispredict
);

`ifdef JALR_RAS_EN
    localparam logic [PW:0] CNT_MAX = (PW+1)'(DEPTH);

    logic [XLEN-1:0] entries [DEPTH];
    logic [PW-1:0]   tos;
    logic [PW:0]     cnt;
    ras_op_e         op;
    logic [XLEN-1:0] push_val;
    logic [PW-1:0]   tos_inc;
    logic [PW-1:0]   tos_dec;
    logic            has_entry;

    assign push_val  = if_pc + XLEN'(4);
    assign tos_inc   = tos + 1'b1;
    assign tos_dec   = tos - 1'b1;
    assign has_entry = (cnt != '0);

    // Classify the IF instruction by its link-register usage
    always_comb begin
        op = RAS_NONE;
        if (if_valid) begin
            if (if_is_jal) begin
                if (is_link(if_rd)) op = RAS_PUSH;
            end else if (if_is_jalr) begin
                case ({is_link(if_rd), is_link(if_rs1)})
                    2'b01:   op = RAS_POP;
                    2'b10:   op = RAS_PUSH;
                    2'b11:   op = (if_rd == if_rs1) ? RAS_PUSH : RAS_POPPUSH;
                    default: op = RAS_NONE;
                endcase
            end
        end
    end

    // Prediction reads the current top; it does not depend on the stall
    assign pred_valid  = (op == RAS_POP || op == RAS_POPPUSH) && has_entry;
    assign pred_target = entries[tos];
    assign ckpt_tos    = tos;
    assign ckpt_cnt    = cnt;

    // Stack state: flush restore wins over the IF update; a full push
    // silently overwrites the oldest entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tos <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (restore) begin
            tos <= restore_tos;
            cnt <= restore_cnt;
        end else if (if_valid && !if_stall) begin
            case (op)
                RAS_PUSH: begin
                    tos              <= tos_inc;
                    entries[tos_inc] <= push_val;
                    if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                end
                RAS_POP: begin
                    if (has_entry) begin
                        tos <= tos_dec;
                        cnt <= cnt - 1'b1;
                    end
                end
                RAS_POPPUSH: begin
                    if (has_entry) begin
                        entries[tos] <= push_val;
                    end else begin
                        tos              <= tos_inc;
                        entries[tos_inc] <= push_val;
                        cnt              <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    logic unused_ras_inputs;

    assign pred_valid  = 1'b0;
    assign pred_target = '0;
    assign ckpt_tos    = '0;
    assign ckpt_cnt    = '0;

    assign unused_ras_inputs = ^{clk, rst, if_valid, if_stall, if_is_jal, if_is_jalr,
                                 if_rd, if_rs1, if_pc, restore, restore_tos, restore_cnt};
`endif

    jalr_target_calc #(.XLEN(XLEN)) u_target_calc (
        .is_jalr  (ex_is_jalr),
        .pc       (ex_pc),
        .rs1_data (ex_rs1_data),
        .imm      (ex_imm),
        .target   (ex_target)
    );

    assign ex_mispredict = ex_valid & ex_is_jalr &
                           (~ex_pred_valid | (ex_pred_target != ex_target));

endmodule

// File: tb/tb_jalr_ras.sv
// Self-checking bench for jalr_ras (DEPTH=8, XLEN=32). Expected values come
// from a behavioural stack model; JALR_RAS_EN selects which build is expected.
module tb_jalr_ras;

`ifdef JALR_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, if_stall, if_is_jal, if_is_jalr;
    logic [4:0]  if_rd, if_rs1;
    logic [31:0] if_pc;
    logic        pred_valid;
    logic [31:0] pred_target;
    logic [2:0]  ckpt_tos;
    logic [3:0]  ckpt_cnt;
    logic        restore;
    logic [2:0]  restore_tos;
    logic [3:0]  restore_cnt;
    logic        ex_valid, ex_is_jalr, ex_pred_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_imm, ex_pred_target;
    logic [31:0] ex_target;
    logic        ex_mispredict;

    always #5 clk = ~clk;

    jalr_ras #(.XLEN(32), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_stall(if_stall),
        .if_is_jal(if_is_jal), .if_is_jalr(if_is_jalr),
        .if_rd(if_rd), .if_rs1(if_rs1), .if_pc(if_pc),
        .pred_valid(pred_valid), .pred_target(pred_target),
        .ckpt_tos(ckpt_tos), .ckpt_cnt(ckpt_cnt),
        .restore(restore), .restore_tos(restore_tos), .restore_cnt(restore_cnt),
        .ex_valid(ex_valid), .ex_is_jalr(ex_is_jalr),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_imm(ex_imm),
        .ex_pred_valid(ex_pred_valid), .ex_pred_target(ex_pred_target),
        .ex_target(ex_target), .ex_mispredict(ex_mispredict)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a circular stack of 8 slots, top index and occupancy
    logic [31:0] m_ent [8];
    int          m_tos;
    int          m_cnt;

    function automatic bit lnk(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    // 0 none, 1 push, 2 pop, 3 pop-then-push
    function automatic int m_op();
        if (!if_valid) return 0;
        if (if_is_jal) return lnk(if_rd) ? 1 : 0;
        if (if_is_jalr) begin
            if (!lnk(if_rd) && lnk(if_rs1)) return 2;
            if (lnk(if_rd) && !lnk(if_rs1)) return 1;
            if (lnk(if_rd) && lnk(if_rs1)) return (if_rd == if_rs1) ? 1 : 3;
        end
        return 0;
    endfunction

    function automatic bit exp_pv();
        int o;
        o = m_op();
        return RAS_EN && (o == 2 || o == 3) && (m_cnt > 0);
    endfunction

    function automatic logic [31:0] exp_pt();
        return RAS_EN ? m_ent[m_tos] : 32'h0;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 8; i++) m_ent[i] = 32'h0;
        m_tos = 0;
        m_cnt = 0;
    endtask

    task automatic m_push(input logic [31:0] v);
        m_tos = (m_tos + 1) % 8;
        m_ent[m_tos] = v;
        if (m_cnt < 8) m_cnt++;
    endtask

    task automatic model_step();
        if (!RAS_EN) return;
        if (restore) begin
            m_tos = int'(restore_tos);
            m_cnt = int'(restore_cnt);
        end else if (if_valid && !if_stall) begin
            case (m_op())
                1: m_push(if_pc + 32'd4);
                2: if (m_cnt > 0) begin m_tos = (m_tos + 7) % 8; m_cnt--; end
                3: if (m_cnt == 0) m_push(if_pc + 32'd4); else m_ent[m_tos] = if_pc + 32'd4;
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_if(input logic v, input logic st, input logic jal, input logic jalr,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] pc);
        if_valid = v; if_stall = st; if_is_jal = jal; if_is_jalr = jalr;
        if_rd = rd; if_rs1 = rs1; if_pc = pc;
    endtask

    task automatic do_reset();
        set_if(0, 0, 0, 0, 5'd0, 5'd0, 32'h0);
        restore = 0; restore_tos = 3'd0; restore_cnt = 4'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_clear();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pv got=%0b exp=0", pred_valid); end
        n_cmp++; if (pred_target !== 32'h0) begin n_fail++; $display("FAIL reset_pt got=%h exp=0", pred_target); end
        n_cmp++; if (ckpt_tos !== 3'd0) begin n_fail++; $display("FAIL reset_tos got=%0d exp=0", ckpt_tos); end
        n_cmp++; if (ckpt_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", ckpt_cnt); end
    endtask

    task automatic test_call_return();
        do_reset();
        set_if(1, 0, 1, 0, 5'd1, 5'd0, 32'h100);
        tick();
        set_if(1, 0, 0, 1, 5'd0, 5'd1, 32'h500);
        #1;
        n_cmp++; if (ckpt_cnt !== (RAS_EN ? 4'd1 : 4'd0)) begin n_fail++; $display("FAIL call_cnt got=%0d exp=%0d", ckpt_cnt, RAS_EN ? 1 : 0); end
        n_cmp++; if (pred_valid !== RAS_EN) begin n_fail++; $display("FAIL ret_pv got=%0b exp=%0b", pred_valid, RAS_EN); end
        n_cmp++; if (pred_target !== (RAS_EN ? 32'h104 : 32'h0)) begin n_fail++; $display("FAIL ret_pt got=%h exp=%h", pred_target, RAS_EN ? 32'h104 : 32'h0); end
        tick();
        set_if(0, 0, 0, 0, 5'd0, 5'd0, 32'h0);
        #1;
        n_cmp++; if (ckpt_cnt !== 4'd0) begin n_fail++; $display("FAIL ret_cnt got=%0d exp=0", ckpt_cnt); end
    endtask

    task automatic test_overflow();
        logic [31:0] want;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_if(1, 0, 1, 0, 5'd1, 5'd0, 32'(i * 16));
            tick();
        end
        set_if(0, 0, 0, 0, 5'd0, 5'd0, 32'h0);
        #1;
        n_cmp++; if (ckpt_cnt !== (RAS_EN ? 4'd8 : 4'd0)) begin n_fail++; $display("FAIL full_cnt got=%0d exp=%0d", ckpt_cnt, RAS_EN ? 8 : 0); end
        for (int k = 0; k < 9; k++) begin
            set_if(1, 0, 0, 1, 5'd0, 5'd5, 32'h900);
            #1;
            want = (RAS_EN && k < 8) ? 32'(32'h84 - k * 16) : 32'h0;
            n_cmp++; if (pred_valid !== (RAS_EN && k < 8)) begin n_fail++; $display("FAIL pop%0d_pv got=%0b exp=%0b", k, pred_valid, RAS_EN && k < 8); end
            if (k < 8) begin
                n_cmp++; if (pred_target !== want) begin n_fail++; $display("FAIL pop%0d_pt got=%h exp=%h", k, pred_target, want); end
            end
            tick();
        end
    endtask

    task automatic test_poppush();
        do_reset();
        set_if(1, 0, 1, 0, 5'd5, 5'd0, 32'h4c);
        tick();
        set_if(1, 0, 0, 1, 5'd1, 5'd5, 32'h200);
        #1;
        n_cmp++; if (pred_valid !== RAS_EN) begin n_fail++; $display("FAIL pp_pv got=%0b exp=%0b", pred_valid, RAS_EN); end
        n_cmp++; if (pred_target !== (RAS_EN ? 32'h50 : 32'h0)) begin n_fail++; $display("FAIL pp_pt got=%h exp=%h", pred_target, RAS_EN ? 32'h50 : 32'h0); end
        tick();
        set_if(1, 0, 0, 1, 5'd1, 5'd1, 32'h300);
        #1;
        n_cmp++; if (pred_target !== (RAS_EN ? 32'h204 : 32'h0)) begin n_fail++; $display("FAIL pp_top got=%h exp=%h", pred_target, RAS_EN ? 32'h204 : 32'h0); end
        n_cmp++; if (ckpt_cnt !== (RAS_EN ? 4'd1 : 4'd0)) begin n_fail++; $display("FAIL pp_cnt got=%0d exp=%0d", ckpt_cnt, RAS_EN ? 1 : 0); end
        n_cmp++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL same_link_pv got=%0b exp=0", pred_valid); end
        tick();
        set_if(0, 0, 0, 0, 5'd0, 5'd0, 32'h0);
        #1;
        n_cmp++; if (ckpt_cnt !== (RAS_EN ? 4'd2 : 4'd0)) begin n_fail++; $display("FAIL same_link_cnt got=%0d exp=%0d", ckpt_cnt, RAS_EN ? 2 : 0); end
        n_cmp++; if (pred_target !== (RAS_EN ? 32'h304 : 32'h0)) begin n_fail++; $display("FAIL same_link_pt got=%h exp=%h", pred_target, RAS_EN ? 32'h304 : 32'h0); end
    endtask

    task automatic test_restore();
        logic [2:0] st;
        logic [3:0] sc;
        do_reset();
        restore = 1; restore_tos = 3'd1; restore_cnt = 4'd2;
        tick();
        restore = 0;
        set_if(1, 0, 1, 0, 5'd1, 5'd0, 32'h60);
        tick();
        set_if(0, 0, 0, 0, 5'd0, 5'd0, 32'h0);
        #1;
        st = ckpt_tos; sc = ckpt_cnt;
        n_cmp++; if (st !== (RAS_EN ? 3'd2 : 3'd0) || sc !== (RAS_EN ? 4'd3 : 4'd0)) begin n_fail++; $display("FAIL ckpt got=%0d/%0d exp=%0d/%0d", st, sc, RAS_EN ? 2 : 0, RAS_EN ? 3 : 0); end
        for (int i = 0; i < 2; i++) begin
            set_if(1, 0, 1, 0, 5'd1, 5'd0, 32'h700 + 32'(i * 4));
            tick();
        end
        set_if(1, 1, 1, 0, 5'd1, 5'd0, 32'h800);
        restore = 1; restore_tos = RAS_EN ? 3'd2 : 3'd0; restore_cnt = RAS_EN ? 4'd3 : 4'd0;
        tick();
        restore = 0;
        set_if(0, 0, 0, 0, 5'd0, 5'd0, 32'h0);
        #1;
        n_cmp++; if (ckpt_tos !== (RAS_EN ? 3'd2 : 3'd0)) begin n_fail++; $display("FAIL rst_tos got=%0d exp=%0d", ckpt_tos, RAS_EN ? 2 : 0); end
        n_cmp++; if (ckpt_cnt !== (RAS_EN ? 4'd3 : 4'd0)) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=%0d", ckpt_cnt, RAS_EN ? 3 : 0); end
        n_cmp++; if (pred_target !== exp_pt()) begin n_fail++; $display("FAIL rst_pt got=%h exp=%h", pred_target, exp_pt()); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_if(1, 0, 1, 0, 5'd1, 5'd0, 32'h1000 + 32'(i * 8));
            tick();
        end
        set_if(1, 0, 0, 1, 5'd0, 5'd1, 32'h2000);
        #1;
        n_cmp++; if (ckpt_cnt !== (RAS_EN ? 4'd5 : 4'd0)) begin n_fail++; $display("FAIL pre_ar_cnt got=%0d exp=%0d", ckpt_cnt, RAS_EN ? 5 : 0); end
        n_cmp++; if (pred_valid !== RAS_EN) begin n_fail++; $display("FAIL pre_ar_pv got=%0b exp=%0b", pred_valid, RAS_EN); end
        rst = 1'b1;
        #1;
        m_clear();
        n_cmp++; if (ckpt_cnt !== 4'd0) begin n_fail++; $display("FAIL ar_cnt got=%0d exp=0", ckpt_cnt); end
        n_cmp++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL ar_pv got=%0b exp=0", pred_valid); end
        n_cmp++; if (pred_target !== 32'h0) begin n_fail++; $display("FAIL ar_pt got=%h exp=0", pred_target); end
        rst = 1'b0;
        set_if(0, 0, 0, 0, 5'd0, 5'd0, 32'h0);
        tick();
    endtask

    task automatic test_ex();
        logic [31:0] t;
        logic        mp;
        ex_valid = 1; ex_is_jalr = 1; ex_pc = 32'h0; ex_rs1_data = 32'h1003; ex_imm = 32'h2;
        ex_pred_valid = 1; ex_pred_target = 32'h1004;
        #1;
        n_cmp++; if (ex_target !== 32'h1004) begin n_fail++; $display("FAIL ex_jalr_t got=%h exp=1004", ex_target); end
        n_cmp++; if (ex_mispredict !== 1'b0) begin n_fail++; $display("FAIL ex_hit got=%0b exp=0", ex_mispredict); end
        ex_pred_target = 32'h1000;
        #1;
        n_cmp++; if (ex_mispredict !== 1'b1) begin n_fail++; $display("FAIL ex_miss got=%0b exp=1", ex_mispredict); end
        ex_is_jalr = 0; ex_pc = 32'h40; ex_imm = 32'hFFFF_FFF8;
        #1;
        n_cmp++; if (ex_target !== 32'h38) begin n_fail++; $display("FAIL ex_jal_t got=%h exp=38", ex_target); end
        n_cmp++; if (ex_mispredict !== 1'b0) begin n_fail++; $display("FAIL ex_jal_mp got=%0b exp=0", ex_mispredict); end
        for (int i = 0; i < 60; i++) begin
            ex_valid = ($urandom % 4) != 0; ex_is_jalr = $urandom % 2;
            ex_pc = $urandom; ex_rs1_data = $urandom; ex_imm = $urandom;
            ex_pred_valid = $urandom % 2;
            if (ex_is_jalr) t = (ex_rs1_data + ex_imm) & 32'hFFFF_FFFE;
            else            t = ex_pc + ex_imm;
            ex_pred_target = ($urandom % 2) ? t : $urandom;
            mp = ex_valid && ex_is_jalr && (!ex_pred_valid || ex_pred_target != t);
            #1;
            n_cmp++; if (ex_target !== t) begin n_fail++; $display("FAIL ex_rand_t%0d got=%h exp=%h", i, ex_target, t); end
            n_cmp++; if (ex_mispredict !== mp) begin n_fail++; $display("FAIL ex_rand_mp%0d got=%0b exp=%0b", i, ex_mispredict, mp); end
        end
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom % 4)
            0:       return 5'd1;
            1:       return 5'd5;
            2:       return 5'd0;
            default: return 5'($urandom % 32);
        endcase
    endfunction

    task automatic test_random();
        int cls;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cls = $urandom % 3;
            set_if(($urandom % 4) != 0, ($urandom % 5) == 0, cls == 1, cls == 2,
                   pick_reg(), pick_reg(), $urandom & 32'hFFFF_FFFC);
            if (i % 97 == 96) if_pc = 32'hFFFF_FFFC;
            restore = ($urandom % 16) == 0;
            restore_tos = 3'($urandom % 8);
            restore_cnt = 4'($urandom % 9);
            #1;
            n_cmp++; if (pred_valid !== exp_pv()) begin n_fail++; $display("FAIL rnd_pv c%0d got=%0b exp=%0b", i, pred_valid, exp_pv()); end
            n_cmp++; if (pred_target !== exp_pt()) begin n_fail++; $display("FAIL rnd_pt c%0d got=%h exp=%h", i, pred_target, exp_pt()); end
            n_cmp++; if (ckpt_tos !== (RAS_EN ? 3'(m_tos) : 3'd0)) begin n_fail++; $display("FAIL rnd_tos c%0d got=%0d exp=%0d", i, ckpt_tos, RAS_EN ? m_tos : 0); end
            n_cmp++; if (ckpt_cnt !== (RAS_EN ? 4'(m_cnt) : 4'd0)) begin n_fail++; $display("FAIL rnd_cnt c%0d got=%0d exp=%0d", i, ckpt_cnt, RAS_EN ? m_cnt : 0); end
            tick();
        end
        restore = 0;
        set_if(0, 0, 0, 0, 5'd0, 5'd0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        restore = 0; restore_tos = 3'd0; restore_cnt = 4'd0;
        set_if(0, 0, 0, 0, 5'd0, 5'd0, 32'h0);
        ex_valid = 0; ex_is_jalr = 0; ex_pc = 0; ex_rs1_data = 0; ex_imm = 0;
        ex_pred_valid = 0; ex_pred_target = 0;
        m_clear();
        test_reset();
        test_call_return();
        test_overflow();
        test_poppush();
        test_restore();
        test_async_reset();
        test_ex();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
